vga_vram_scanout: RTL

Downstream display stage for the VRAM written by the CPU's `STC` instructions. It generates 640x480@60 Hz VGA timing and reads the 80x60-cell VRAM one cell per 8x8 pixel block. Each 3-bit cell color drives the R/G/B pins, so every square the ROM program draws appears on screen.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_timing_counter.sv | 86 ++++++++
 rtl/vga_vram_scanout.sv | 104 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA scan-out definitions: default timing, sync polarity, VRAM geometry and colors.
package vga_pkg;

  localparam int unsigned DEF_H_VISIBLE  = 640;
  localparam int unsigned DEF_H_FRONT    = 16;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_BACK     = 48;
  localparam int unsigned DEF_V_VISIBLE  = 480;
  localparam int unsigned DEF_V_FRONT    = 10;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BACK     = 33;
  localparam int unsigned DEF_CELL_SHIFT = 3;
  localparam int unsigned DEF_PIX_DIV    = 2;

  localparam int unsigned VRAM_COLS = 80;
  localparam int unsigned VRAM_ROWS = 60;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ADDR_W = 13;

  localparam logic SYNC_ACTIVE = 1'b0;

  localparam logic [2:0] COLOR_BLACK   = 3'b000;
  localparam logic [2:0] COLOR_BLUE    = 3'b001;
  localparam logic [2:0] COLOR_CYAN    = 3'b011;
  localparam logic [2:0] COLOR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOR_WHITE   = 3'b111;

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel divider, horizontal/vertical counters and the visible/sync/frame-start decodes.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned PIX_DIV   = DEF_PIX_DIV
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_pix_en,
  output logic [CNT_W-1:0] o_hcnt,
  output logic [CNT_W-1:0] o_vcnt,
  output logic             o_visible,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_frame_start
);

  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             r_frame_start;

  logic w_pix_en;
  logic w_h_last;
  logic w_v_last;
  logic w_hsync_win;
  logic w_vsync_win;

  assign w_pix_en    = (r_div == DIV_LAST);
  assign w_h_last    = (r_hcnt == H_LAST);
  assign w_v_last    = (r_vcnt == V_LAST);
  assign w_hsync_win = (r_hcnt >= H_SYNC_START) && (r_hcnt < H_SYNC_END);
  assign w_vsync_win = (r_vcnt >= V_SYNC_START) && (r_vcnt < V_SYNC_END);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div         <= '0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_pix_en ? '0 : r_div + 1'b1;
      // Pulse lands on the Clock right after the (last,last) -> (0,0) wrap.
      r_frame_start <= w_pix_en && w_h_last && w_v_last;
      if (w_pix_en) begin
        if (w_h_last) begin
          r_hcnt <= '0;
          r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
        end else begin
          r_hcnt <= r_hcnt + 1'b1;
        end
      end
    end
  end

  assign o_pix_en      = w_pix_en;
  assign o_hcnt        = r_hcnt;
  assign o_vcnt        = r_vcnt;
  assign o_visible     = (r_hcnt < H_VIS_END) && (r_vcnt < V_VIS_END);
  assign o_hsync       = w_hsync_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign o_vsync       = w_vsync_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_vram_scanout.sv
// VGA scan-out of the cell VRAM: address generation and the registered color/sync stage.
// Optional macro VGA_GRID_EN paints visible cell-boundary pixels white.
module vga_vram_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter int unsigned CELL_SHIFT = DEF_CELL_SHIFT,
  parameter int unsigned VRAM_W     = VRAM_COLS,
  parameter int unsigned PIX_DIV    = DEF_PIX_DIV
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] oVRAMAddr,
  input  logic [2:0]        iVRAMData,
  output logic              oVGA_R,
  output logic              oVGA_G,
  output logic              oVGA_B,
  output logic              oHSync,
  output logic              oVSync,
  output logic              oFrameStart
);

  logic             w_pix_en;
  logic [CNT_W-1:0] w_hcnt;
  logic [CNT_W-1:0] w_vcnt;
  logic             w_visible;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_frame_start;

  logic [ADDR_W-1:0] w_col;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_pix;

  logic [2:0] r_rgb;
  logic       r_hsync;
  logic       r_vsync;

  vga_timing_counter #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK),
    .PIX_DIV   (PIX_DIV)
  ) u_timing (
    .i_clk         (Clock),
    .i_rst_n       (Reset),
    .o_pix_en      (w_pix_en),
    .o_hcnt        (w_hcnt),
    .o_vcnt        (w_vcnt),
    .o_visible     (w_visible),
    .o_hsync       (w_hsync),
    .o_vsync       (w_vsync),
    .o_frame_start (w_frame_start)
  );

  // Multiply by a constant row width; at 80 this reduces to (row<<6)+(row<<4).
  assign w_col  = ADDR_W'(w_hcnt >> CELL_SHIFT);
  assign w_row  = ADDR_W'(w_vcnt >> CELL_SHIFT);
  assign w_addr = w_row * ADDR_W'(VRAM_W) + w_col;

  assign oVRAMAddr = w_visible ? w_addr : '0;

`ifdef VGA_GRID_EN
  logic w_grid;
  assign w_grid = (w_hcnt[CELL_SHIFT-1:0] == '0) || (w_vcnt[CELL_SHIFT-1:0] == '0);
  assign w_pix  = w_grid ? COLOR_WHITE : iVRAMData;
`else
  assign w_pix  = iVRAMData;
`endif

  // Counters are still on the pixel whose data was read, so visible/syncs line up with color.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_rgb   <= COLOR_BLACK;
      r_hsync <= ~SYNC_ACTIVE;
      r_vsync <= ~SYNC_ACTIVE;
    end else if (w_pix_en) begin
      r_rgb   <= w_visible ? w_pix : COLOR_BLACK;
      r_hsync <= w_hsync;
      r_vsync <= w_vsync;
    end
  end

  assign oVGA_R      = r_rgb[2];
  assign oVGA_G      = r_rgb[1];
  assign oVGA_B      = r_rgb[0];
  assign oHSync      = r_hsync;
  assign oVSync      = r_vsync;
  assign oFrameStart = w_frame_start;

endmodule
